gecko_axi_loader: RTL and testbench

- AXI4 write initiator that loads a program image into the gecko_compute AXI4 responder port before or while the core is held idle.
- Takes a load command (base address, word count) and a 32-bit word stream, then issues INCR write bursts on flat AXI4 master ports.
- Reports completion and error status flags.
- Sits between the host or boot-ROM streamer and the gecko_compute AXI4 slave port.

---
 rtl/gecko_axi_loader.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_gecko_axi_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gecko_axi_loader.sv
`default_nettype none
// ============================================================================
// Module   : gecko_axi_loader
// Purpose  : AXI4 write initiator that streams a program image into
//            gecko_compute as 4 KB-safe INCR bursts, one burst in flight.
// Option   : GECKO_AXI_LOADER_READBACK_EN adds read-back with checksum compare
// Revision : 1.0
// ============================================================================
module gecko_axi_loader #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int ID_WIDTH    = 1,
   parameter int USER_WIDTH  = 1,
   parameter int MAX_BURST   = 16,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [ADDR_WIDTH-1:0]  cmd_addr,
   input  logic [COUNT_WIDTH-1:0] cmd_words,
   input  logic                   data_valid,
   output logic                   data_ready,
   input  logic [DATA_WIDTH-1:0]  data_payload,
   output logic                   axi_awvalid,
   input  logic                   axi_awready,
   output logic [ADDR_WIDTH-1:0]  axi_awaddr,
   output logic [7:0]             axi_awlen,
   output logic [2:0]             axi_awsize,
   output logic [1:0]             axi_awburst,
   output logic [3:0]             axi_awcache,
   output logic                   axi_awlock,
   output logic [2:0]             axi_awprot,
   output logic [3:0]             axi_awqos,
   output logic [USER_WIDTH-1:0]  axi_awuser,
   output logic [ID_WIDTH-1:0]    axi_awid,
   output logic                   axi_wvalid,
   input  logic                   axi_wready,
   output logic [DATA_WIDTH-1:0]  axi_wdata,
   output logic [3:0]             axi_wstrb,
   output logic                   axi_wlast,
   input  logic                   axi_bvalid,
   output logic                   axi_bready,
   input  logic [1:0]             axi_bresp,
   input  logic [ID_WIDTH-1:0]    axi_bid,
`ifdef GECKO_AXI_LOADER_READBACK_EN
   output logic                   axi_arvalid,
   input  logic                   axi_arready,
   output logic [ADDR_WIDTH-1:0]  axi_araddr,
   output logic [7:0]             axi_arlen,
   output logic [2:0]             axi_arsize,
   output logic [1:0]             axi_arburst,
   output logic [3:0]             axi_arcache,
   output logic                   axi_arlock,
   output logic [2:0]             axi_arprot,
   output logic [3:0]             axi_arqos,
   output logic [USER_WIDTH-1:0]  axi_aruser,
   output logic [ID_WIDTH-1:0]    axi_arid,
   input  logic                   axi_rvalid,
   output logic                   axi_rready,
   input  logic [DATA_WIDTH-1:0]  axi_rdata,
   input  logic [1:0]             axi_rresp,
   input  logic                   axi_rlast,
   input  logic [ID_WIDTH-1:0]    axi_rid,
   output logic                   mismatch_flag,
`endif
   output logic                   busy,
   output logic                   done_flag,
   output logic                   error_flag
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_AW      = 3'd1;
   localparam logic [2:0] S_W       = 3'd2;
   localparam logic [2:0] S_B       = 3'd3;
   localparam logic [2:0] S_READ_AR = 3'd4;
   localparam logic [2:0] S_READ_R  = 3'd5;
   localparam int         CMP_W     = (COUNT_WIDTH > 11) ? COUNT_WIDTH : 11;

   logic [2:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [COUNT_WIDTH-1:0] rem_q, rem_d;
   logic [7:0]             len_q, len_d;
   logic [7:0]             beat_q, beat_d;
   logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

   logic [8:0]             beats;
   logic [ADDR_WIDTH-1:0]  next_addr;
   logic [COUNT_WIDTH-1:0] next_rem;
   logic [ADDR_WIDTH-1:0]  cmd_addr_al;
   logic                   w_beat;
   logic                   unused_ok;

   // Burst beats = min(MAX_BURST, remaining, words left before the 4 KB line).
   function automatic logic [7:0] f_len(input logic [ADDR_WIDTH-1:0]  a,
                                        input logic [COUNT_WIDTH-1:0] rem);
      logic [10:0] to4k;
      logic [10:0] n;
      to4k = 11'd1024 - {1'b0, a[11:2]};
      n    = (11'(MAX_BURST) < to4k) ? 11'(MAX_BURST) : to4k;
      if (CMP_W'(rem) < CMP_W'(n)) n = 11'(rem);
      return 8'(n - 11'd1);
   endfunction

   assign beats       = 9'(len_q) + 9'd1;
   assign next_addr   = addr_q + ADDR_WIDTH'({beats, 2'b00});
   assign next_rem    = rem_q - COUNT_WIDTH'(beats);
   assign cmd_addr_al = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};

   assign cmd_ready   = (state_q == S_IDLE);
   assign axi_awvalid = (state_q == S_AW);
   assign axi_awaddr  = addr_q;
   assign axi_awlen   = len_q;
   assign axi_awsize  = 3'b010;
   assign axi_awburst = 2'b01;
   assign axi_awcache = 4'b0011;
   assign axi_awlock  = 1'b0;
   assign axi_awprot  = 3'b000;
   assign axi_awqos   = 4'b0000;
   assign axi_awuser  = '0;
   assign axi_awid    = '0;
   assign axi_wvalid  = (state_q == S_W) && data_valid;
   assign data_ready  = (state_q == S_W) && axi_wready;
   assign axi_wdata   = (state_q == S_W) ? data_payload : '0;
   assign axi_wstrb   = 4'hF;
   assign axi_wlast   = (state_q == S_W) && (beat_q == len_q);
   assign axi_bready  = (state_q == S_B);
   assign w_beat      = axi_wvalid && axi_wready;
   assign busy        = busy_q;
   assign done_flag   = done_q;
   assign error_flag  = err_q;

`ifdef GECKO_AXI_LOADER_READBACK_EN
   logic [ADDR_WIDTH-1:0]  base_q, base_d;
   logic [COUNT_WIDTH-1:0] words_q, words_d;
   logic [31:0]            wsum_q, wsum_d, rsum_q, rsum_d;
   logic                   mism_q, mism_d;

   assign axi_arvalid   = (state_q == S_READ_AR);
   assign axi_araddr    = addr_q;
   assign axi_arlen     = len_q;
   assign axi_arsize    = 3'b010;
   assign axi_arburst   = 2'b01;
   assign axi_arcache   = 4'b0011;
   assign axi_arlock    = 1'b0;
   assign axi_arprot    = 3'b000;
   assign axi_arqos     = 4'b0000;
   assign axi_aruser    = '0;
   assign axi_arid      = '0;
   assign axi_rready    = (state_q == S_READ_R);
   assign mismatch_flag = mism_q;
   assign unused_ok     = ^{cmd_addr[1:0], axi_bid, axi_rid};
`else
   assign unused_ok     = ^{cmd_addr[1:0], axi_bid};
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      len_d   = len_q;
      beat_d  = beat_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
`ifdef GECKO_AXI_LOADER_READBACK_EN
      base_d  = base_q;
      words_d = words_q;
      wsum_d  = wsum_q;
      rsum_d  = rsum_q;
      mism_d  = mism_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr_al;
               rem_d  = cmd_words;
               beat_d = 8'd0;
               err_d  = 1'b0;
`ifdef GECKO_AXI_LOADER_READBACK_EN
               base_d  = cmd_addr_al;
               words_d = cmd_words;
               wsum_d  = 32'd0;
               rsum_d  = 32'd0;
               mism_d  = 1'b0;
`endif
               if (cmd_words == '0) begin
                  done_d = 1'b1;
               end else begin
                  done_d  = 1'b0;
                  busy_d  = 1'b1;
                  len_d   = f_len(cmd_addr_al, cmd_words);
                  state_d = S_AW;
               end
            end
         end
         S_AW: begin
            if (axi_awready) state_d = S_W;
         end
         S_W: begin
            if (w_beat) begin
`ifdef GECKO_AXI_LOADER_READBACK_EN
               wsum_d = wsum_q + 32'(data_payload);
`endif
               if (beat_q == len_q) begin
                  beat_d  = 8'd0;
                  state_d = S_B;
               end else begin
                  beat_d = beat_q + 8'd1;
               end
            end
         end
         S_B: begin
            if (axi_bvalid) begin
               if (axi_bresp != 2'b00) err_d = 1'b1;
               addr_d = next_addr;
               rem_d  = next_rem;
               if (next_rem == '0) begin
`ifdef GECKO_AXI_LOADER_READBACK_EN
                  // Replay the exact burst split from the original base.
                  addr_d  = base_q;
                  rem_d   = words_q;
                  len_d   = f_len(base_q, words_q);
                  state_d = S_READ_AR;
`else
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_IDLE;
`endif
               end else begin
                  len_d   = f_len(next_addr, next_rem);
                  state_d = S_AW;
               end
            end
         end
`ifdef GECKO_AXI_LOADER_READBACK_EN
         S_READ_AR: begin
            if (axi_arready) state_d = S_READ_R;
         end
         S_READ_R: begin
            if (axi_rvalid) begin
               rsum_d = rsum_q + 32'(axi_rdata);
               if (axi_rresp != 2'b00) err_d = 1'b1;
               if (axi_rlast) begin
                  addr_d = next_addr;
                  rem_d  = next_rem;
                  if (next_rem == '0) begin
                     mism_d  = (rsum_d != wsum_q);
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end else begin
                     len_d   = f_len(next_addr, next_rem);
                     state_d = S_READ_AR;
                  end
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         len_q   <= 8'd0;
         beat_q  <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef GECKO_AXI_LOADER_READBACK_EN
         base_q  <= '0;
         words_q <= '0;
         wsum_q  <= 32'd0;
         rsum_q  <= 32'd0;
         mism_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef GECKO_AXI_LOADER_READBACK_EN
         base_q  <= base_d;
         words_q <= words_d;
         wsum_q  <= wsum_d;
         rsum_q  <= rsum_d;
         mism_q  <= mism_d;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gecko_axi_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gecko_axi_loader
// Purpose  : Randomized bench for gecko_axi_loader against a burst-split model
// Revision : 1.0
// ============================================================================
module tb_gecko_axi_loader;

   localparam int MB = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_addr;
   logic [15:0] cmd_words;
   logic        data_valid, data_ready;
   logic [31:0] data_payload;
   logic        axi_awvalid, axi_awready;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic [3:0]  axi_awcache;
   logic        axi_awlock;
   logic [2:0]  axi_awprot;
   logic [3:0]  axi_awqos;
   logic [0:0]  axi_awuser, axi_awid;
   logic        axi_wvalid, axi_wready;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast;
   logic        axi_bvalid, axi_bready;
   logic [1:0]  axi_bresp;
   logic [0:0]  axi_bid;
   logic        busy, done_flag, error_flag;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] a;
      int          n;
   } burst_t;
   burst_t exp_q[$];

   always #5 clk = ~clk;

   gecko_axi_loader dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
      .data_valid(data_valid), .data_ready(data_ready), .data_payload(data_payload),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_awcache(axi_awcache), .axi_awlock(axi_awlock), .axi_awprot(axi_awprot),
      .axi_awqos(axi_awqos), .axi_awuser(axi_awuser), .axi_awid(axi_awid),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
      .busy(busy), .done_flag(done_flag), .error_flag(error_flag)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference burst split: min(MAX_BURST, remaining, words to next 4 KB line).
   task automatic model(input logic [31:0] addr, input int words);
      logic [31:0] a;
      int rem, to4k, n;
      a   = {addr[31:2], 2'b00};
      rem = words;
      exp_q.delete();
      while (rem > 0) begin
         to4k = (4096 - int'(a % 32'd4096)) / 4;
         n = MB;
         if (rem < n)  n = rem;
         if (to4k < n) n = to4k;
         exp_q.push_back('{a, n});
         a   = a + 32'(4 * n);
         rem = rem - n;
      end
   endtask

   task automatic run_cmd(input logic [31:0] addr, input int words, input int bp,
                          input int err_idx, input string tag);
      logic [31:0] src[$];
      logic [31:0] aw_a[$];
      int          aw_n[$];
      logic [31:0] wd[$];
      logic        wl[$];
      logic [31:0] st_a;
      logic [7:0]  st_l;
      int sidx = 0, cyc = 0, nb = 0, proto = 0, stab = 0, k = 0;
      bit pend_b = 0, in_burst = 0, stall = 0, btook = 0, fin = 0, exp_err;

      model(addr, words);
      exp_err = (err_idx >= 0) && (err_idx < exp_q.size());
      for (int i = 0; i < words; i++) src.push_back($urandom);

      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = addr; cmd_words = 16'(words);
      #1 check_eq({tag, "/cmd_ready"}, cmd_ready, 1'b1);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_words = 16'($urandom);
      check_eq({tag, "/aw_latency"}, axi_awvalid, words != 0);
      if (words != 0) begin
         check_eq({tag, "/flags_cleared"}, {done_flag, error_flag, busy}, 3'b001);
      end

      while (!fin && cyc < 4000) begin
         if (btook) begin axi_bvalid = 1'b0; btook = 0; end
         axi_awready  = ($urandom_range(99) >= bp);
         axi_wready   = ($urandom_range(99) >= bp);
         data_valid   = (sidx < words) && ($urandom_range(99) >= bp);
         data_payload = (sidx < words) ? src[sidx] : $urandom;
         if (pend_b && !axi_bvalid && $urandom_range(99) >= bp) begin
            axi_bvalid = 1'b1;
            axi_bresp  = (nb == err_idx) ? 2'b10 : 2'b00;
         end
         #1;
         if (axi_wvalid && (!in_burst || axi_awvalid)) proto++;
         if (axi_wvalid && axi_wready) begin
            wd.push_back(axi_wdata);
            wl.push_back(axi_wlast);
            if (data_ready !== 1'b1) proto++;
            if (axi_wlast) begin in_burst = 0; pend_b = 1; end
         end
         if (data_valid && data_ready) sidx++;
         if (axi_awvalid) begin
            if (pend_b || in_burst) proto++;
            if (stall && (axi_awaddr !== st_a || axi_awlen !== st_l)) stab++;
            if (axi_awready) begin
               aw_a.push_back(axi_awaddr);
               aw_n.push_back(int'(axi_awlen) + 1);
               in_burst = 1; stall = 0;
            end else begin
               stall = 1; st_a = axi_awaddr; st_l = axi_awlen;
            end
         end else if (stall) begin
            stab++; stall = 0;
         end
         if (axi_bvalid && axi_bready) begin nb++; pend_b = 0; btook = 1; end
         cyc++;
         fin = (nb == exp_q.size()) && (cyc >= 3);
         @(negedge clk);
      end
      axi_bvalid = 1'b0; data_valid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;

      check_eq({tag, "/no_timeout"}, fin, 1'b1);
      check_eq({tag, "/done"}, done_flag, 1'b1);
      check_eq({tag, "/busy"}, busy, 1'b0);
      check_eq({tag, "/error"}, error_flag, exp_err);
      check_eq({tag, "/protocol"}, 64'(proto), 64'd0);
      check_eq({tag, "/aw_stable"}, 64'(stab), 64'd0);
      check_eq({tag, "/n_bursts"}, 64'(aw_a.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < aw_a.size(); i++) begin
         check_eq($sformatf("%s/aw%0d_addr", tag, i), aw_a[i], exp_q[i].a);
         check_eq($sformatf("%s/aw%0d_beats", tag, i), 64'(aw_n[i]), 64'(exp_q[i].n));
      end
      check_eq({tag, "/n_beats"}, 64'(wd.size()), 64'(words));
      foreach (exp_q[b]) begin
         for (int j = 0; j < exp_q[b].n; j++) begin
            if (k < wd.size()) begin
               check_eq($sformatf("%s/w%0d", tag, k), {31'd0, wl[k], wd[k]},
                        {31'd0, (j == exp_q[b].n - 1), src[k]});
            end
            k++;
         end
      end
   endtask

   task automatic reset_mid_burst();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_words = 16'd8;
      axi_awready = 1'b1; axi_wready = 1'b1; data_valid = 1'b1; data_payload = 32'h1234_5678;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("rst/in_w", {axi_wvalid, busy}, 2'b11);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("rst/valids", {axi_awvalid, axi_wvalid, axi_bready}, 3'b000);
      check_eq("rst/flags", {busy, done_flag, error_flag, cmd_ready, data_ready}, 5'b00010);
      @(negedge clk);
      rst = 1'b1; data_valid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
      @(negedge clk);
      check_eq("rst/idle", {axi_awvalid, axi_wvalid, busy}, 3'b000);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_words = '0;
      data_valid = 1'b1; data_payload = 32'hDEAD_BEEF;
      axi_awready = 1'b0; axi_wready = 1'b1; axi_bvalid = 1'b0; axi_bresp = 2'b00; axi_bid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("reset/valids", {axi_awvalid, axi_wvalid, axi_bready}, 3'b000);
      check_eq("reset/ready", {cmd_ready, data_ready}, 2'b10);
      check_eq("reset/flags", {busy, done_flag, error_flag}, 3'b000);
      check_eq("reset/aw", {axi_awaddr, axi_awlen}, 40'd0);
      check_eq("reset/wdata", axi_wdata, 32'd0);
      check_eq("consts", {axi_awsize, axi_awburst, axi_awcache, axi_awlock, axi_awprot,
                          axi_awqos, axi_awuser, axi_awid, axi_wstrb},
               {3'b010, 2'b01, 4'b0011, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'hF});
      data_valid = 1'b0; axi_wready = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      run_cmd(32'h0000_0000, 4,  0,  -1, "single");
      run_cmd(32'h0000_0100, 40, 0,  -1, "three");
      run_cmd(32'h0000_0FF8, 5,  0,  -1, "cross4k");
      run_cmd(32'h0000_03F3, 20, 40, -1, "backpressure");
      run_cmd(32'h0000_0400, 40, 20, 1,  "bresp_err");
      run_cmd(32'h0000_0800, 0,  0,  -1, "zero");
      run_cmd(32'hFFFF_FFF0, 8,  10, -1, "wrap");
      reset_mid_burst();
      run_cmd(32'h0000_2000, 6,  0,  -1, "after_rst");
      for (int t = 0; t < 6; t++) begin
         a = $urandom;
         if ($urandom_range(1) == 1) a[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
         run_cmd(a, int'($urandom_range(1, 50)), int'($urandom_range(0, 50)),
                 int'($urandom_range(0, 3)) - 1, $sformatf("rand%0d", t));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
